// File: rtl/iic_access_arbiter.sv
// -----------------------------------------------------------------------------
// iic_access_arbiter
//   Shares one camera IIC driver between two command requesters:
//   requester 0 is the OV5647 init sequencer, requester 1 is the runtime
//   register tuner. Each transaction is granted to one requester, launched
//   with a single write or read strobe, and followed through the driver busy
//   flag. Start and busy timeouts end a transaction with an error.
//
// Ports
//   clk, Rst_N                 100 MHz system clock, async active-low reset
//   Req[1:0], Req_Rd[1:0]      level requests and read/write select
//   Req_Addr0/1, Req_Reg_Addr0/1, Req_Data0/1, Req_Reg2Addr[1:0]
//                              per-requester transaction fields
//   Done[1:0], Err[1:0]        one-cycle completion / error to the owner
//   Rd_Data[7:0]               last successful read result
//   Addr, Reg_Addr, Data, Reg_2Addr, IIC_Write, IIC_Read
//                              command and strobes to the driver
//   IIC_Busy, IIC_Read_Data    driver status and read data
//   Grant[1:0]                 one-hot owner, LAUNCH through FINISH
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   S_IDLE      | no owner; picks a winner when a request is up and driver idle
//   S_LAUNCH    | one cycle, write or read strobe to the driver
//   S_WAIT_START| waiting for the driver to raise busy (START_WAIT limit)
//   S_WAIT_END  | waiting for busy to fall (BUSY_TIMEOUT limit)
//   S_FINISH    | one cycle, Done/Err to the owner, pointer update
// -----------------------------------------------------------------------------
module iic_access_arbiter #(
   parameter int START_WAIT   = 16,
   parameter int BUSY_TIMEOUT = 2000000,
   parameter int CNT_W        = 21
) (
   input  logic        clk,
   input  logic        Rst_N,
   input  logic [1:0]  Req,
   input  logic [1:0]  Req_Rd,
   input  logic [7:0]  Req_Addr0,
   input  logic [7:0]  Req_Addr1,
   input  logic [15:0] Req_Reg_Addr0,
   input  logic [15:0] Req_Reg_Addr1,
   input  logic [7:0]  Req_Data0,
   input  logic [7:0]  Req_Data1,
   input  logic [1:0]  Req_Reg2Addr,
   output logic [1:0]  Done,
   output logic [1:0]  Err,
   output logic [7:0]  Rd_Data,
   output logic [7:0]  Addr,
   output logic [15:0] Reg_Addr,
   output logic [7:0]  Data,
   output logic        Reg_2Addr,
   output logic        IIC_Write,
   output logic        IIC_Read,
   input  logic        IIC_Busy,
   input  logic [7:0]  IIC_Read_Data,
   output logic [1:0]  Grant
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_START,
      S_WAIT_END,
      S_FINISH
   } state_t;

   localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_WAIT);
   localparam logic [CNT_W-1:0] BUSY_CNT  = CNT_W'(BUSY_TIMEOUT);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic              err_q, err_d;
   logic              last_q, last_d;
   logic [1:0]        grant_q, grant_d;
   logic              rd_q, rd_d;
   logic [7:0]        addr_q, addr_d;
   logic [15:0]       reg_addr_q, reg_addr_d;
   logic [7:0]        data_q, data_d;
   logic              reg2_q, reg2_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic              win;

   always_ff @(posedge clk or negedge Rst_N) begin
      if (!Rst_N) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         last_q     <= 1'b1;   // "last served = 1" so requester 0 wins first
         grant_q    <= 2'b00;
         rd_q       <= 1'b0;
         addr_q     <= '0;
         reg_addr_q <= '0;
         data_q     <= '0;
         reg2_q     <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         rd_q       <= rd_d;
         addr_q     <= addr_d;
         reg_addr_q <= reg_addr_d;
         data_q     <= data_d;
         reg2_q     <= reg2_d;
         rd_data_q  <= rd_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      last_d     = last_q;
      grant_d    = grant_q;
      rd_d       = rd_q;
      addr_d     = addr_q;
      reg_addr_d = reg_addr_q;
      data_d     = data_q;
      reg2_d     = reg2_q;
      rd_data_d  = rd_data_q;

      // saturating increment: the counter must never wrap back to zero
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

      // on contention the requester not served last wins
      win = (Req == 2'b11) ? ~last_q : Req[1];

      case (state_q)
         S_IDLE: begin
            if ((Req != 2'b00) && !IIC_Busy) begin
               grant_d    = win ? 2'b10 : 2'b01;
               rd_d       = Req_Rd[win];
               addr_d     = win ? Req_Addr1     : Req_Addr0;
               reg_addr_d = win ? Req_Reg_Addr1 : Req_Reg_Addr0;
               data_d     = win ? Req_Data1     : Req_Data0;
               reg2_d     = Req_Reg2Addr[win];
               state_d    = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (IIC_Busy) begin
               cnt_d   = '0;
               state_d = S_WAIT_END;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == START_CNT) begin
                  err_d   = 1'b1;
                  state_d = S_FINISH;
               end
            end
         end
         S_WAIT_END: begin
            if (!IIC_Busy) begin
               // captured on entry to FINISH so it is valid in the Done cycle
               if (rd_q) rd_data_d = IIC_Read_Data;
               state_d = S_FINISH;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == BUSY_CNT) begin
                  err_d   = 1'b1;
                  state_d = S_FINISH;
               end
            end
         end
         S_FINISH: begin
            last_d  = grant_q[1];
            grant_d = 2'b00;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign Done      = (state_q == S_FINISH) ? grant_q : 2'b00;
   assign Err       = ((state_q == S_FINISH) && err_q) ? grant_q : 2'b00;
   assign IIC_Write = (state_q == S_LAUNCH) && !rd_q;
   assign IIC_Read  = (state_q == S_LAUNCH) && rd_q;
   assign Grant     = grant_q;
   assign Rd_Data   = rd_data_q;
   assign Addr      = addr_q;
   assign Reg_Addr  = reg_addr_q;
   assign Data      = data_q;
   assign Reg_2Addr = reg2_q;

endmodule

// File: tb/tb_iic_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_iic_access_arbiter
//   Self-checking bench for iic_access_arbiter. A sequential driver model
//   answers each strobe with a programmable busy delay/length; expected
//   owner, latency, error and read data come from a small reference model.
// -----------------------------------------------------------------------------
module tb_iic_access_arbiter;

   localparam int START_WAIT = 16;
   localparam int BUSY_TO    = 100;
   localparam int CNT_W      = 21;

   logic        clk = 1'b0;
   logic        Rst_N;
   logic [1:0]  Req, Req_Rd, Req_Reg2Addr;
   logic [7:0]  Req_Addr0, Req_Addr1, Req_Data0, Req_Data1;
   logic [15:0] Req_Reg_Addr0, Req_Reg_Addr1;
   logic [1:0]  Done, Err, Grant;
   logic [7:0]  Rd_Data, Addr, Data, IIC_Read_Data;
   logic [15:0] Reg_Addr;
   logic        Reg_2Addr, IIC_Write, IIC_Read, IIC_Busy;

   int          n_chk  = 0;
   int          n_fail = 0;
   int          last_srv;
   logic [7:0]  model_rd;

   typedef struct {
      int          s_lat;
      logic        s_wr;
      logic        s_rd;
      logic [1:0]  s_gnt;
      logic [32:0] s_fields;
      int          extra;
      int          d_t;
      logic [1:0]  d_done;
      logic [1:0]  d_err;
      logic [7:0]  d_rdata;
   } obs_t;

   always #5 clk = ~clk;

   iic_access_arbiter #(
      .START_WAIT  (START_WAIT),
      .BUSY_TIMEOUT(BUSY_TO),
      .CNT_W       (CNT_W)
   ) dut (
      .clk          (clk),
      .Rst_N        (Rst_N),
      .Req          (Req),
      .Req_Rd       (Req_Rd),
      .Req_Addr0    (Req_Addr0),
      .Req_Addr1    (Req_Addr1),
      .Req_Reg_Addr0(Req_Reg_Addr0),
      .Req_Reg_Addr1(Req_Reg_Addr1),
      .Req_Data0    (Req_Data0),
      .Req_Data1    (Req_Data1),
      .Req_Reg2Addr (Req_Reg2Addr),
      .Done         (Done),
      .Err          (Err),
      .Rd_Data      (Rd_Data),
      .Addr         (Addr),
      .Reg_Addr     (Reg_Addr),
      .Data         (Data),
      .Reg_2Addr    (Reg_2Addr),
      .IIC_Write    (IIC_Write),
      .IIC_Read     (IIC_Read),
      .IIC_Busy     (IIC_Busy),
      .IIC_Read_Data(IIC_Read_Data),
      .Grant        (Grant)
   );

   // ---------------- reference model ----------------
   function automatic int rr_pick(input logic [1:0] req, input int last);
      if (req == 2'b11) return 1 - last;
      return req[1] ? 1 : 0;
   endfunction

   // Done position counted in cycles after the strobe cycle.
   // d = cycles from strobe to busy rise (0 = never), L = busy length (<0 = stuck)
   function automatic int exp_done_t(input int d, input int L);
      if (d == 0 || d > START_WAIT) return START_WAIT + 1;
      if (L < 0 || L > BUSY_TO) return d + 1 + BUSY_TO;
      return d + 1 + L;
   endfunction

   function automatic logic exp_err(input int d, input int L);
      return (d == 0 || d > START_WAIT || L < 0 || L > BUSY_TO);
   endfunction

   function automatic logic [32:0] exp_fields(input int r);
      if (r == 1) return {Req_Addr1, Req_Reg_Addr1, Req_Data1, Req_Reg2Addr[1]};
      return {Req_Addr0, Req_Reg_Addr0, Req_Data0, Req_Reg2Addr[0]};
   endfunction

   // ---------------- stimulus helpers (observe only) ----------------
   task automatic apply_reset();
      Rst_N = 1'b0; Req = 2'b00; IIC_Busy = 1'b0; IIC_Read_Data = 8'h00;
      repeat (2) @(negedge clk);
      Rst_N = 1'b1;
      @(negedge clk);
      last_srv = 1;
      model_rd = 8'h00;
   endtask

   task automatic set_fields(input int r);
      if (r == 1) begin
         Req_Addr1 = 8'($urandom); Req_Reg_Addr1 = 16'($urandom); Req_Data1 = 8'($urandom);
      end else begin
         Req_Addr0 = 8'($urandom); Req_Reg_Addr0 = 16'($urandom); Req_Data0 = 8'($urandom);
      end
      Req_Rd[r]       = 1'($urandom_range(1, 0));
      Req_Reg2Addr[r] = 1'($urandom_range(1, 0));
   endtask

   // Called at a negedge with requests set up. Returns when Done is seen
   // (at that negedge) or the budget runs out.
   task automatic drive_txn(input int d, input int L, input logic [7:0] rdat,
                            input int budget, output obs_t o);
      o.s_lat = -1; o.s_wr = 1'b0; o.s_rd = 1'b0; o.s_gnt = 2'b00; o.s_fields = '0;
      o.extra = 0; o.d_t = -1; o.d_done = 2'b00; o.d_err = 2'b00; o.d_rdata = 8'h00;
      for (int k = 1; k <= 8 && o.s_lat < 0; k++) begin
         @(negedge clk);
         if (IIC_Write || IIC_Read) begin
            o.s_lat = k; o.s_wr = IIC_Write; o.s_rd = IIC_Read; o.s_gnt = Grant;
            o.s_fields = {Addr, Reg_Addr, Data, Reg_2Addr};
         end
      end
      if (o.s_lat < 0) return;
      IIC_Read_Data = rdat;
      for (int t = 1; t <= budget && o.d_t < 0; t++) begin
         @(negedge clk);
         if (IIC_Write || IIC_Read) o.extra++;
         if (Done != 2'b00) begin
            o.d_t = t; o.d_done = Done; o.d_err = Err; o.d_rdata = Rd_Data;
         end else begin
            IIC_Busy = (d > 0) && (t >= d) && ((L < 0) || (t < d + L));
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      n_chk++; if ({Done, Err, Grant} !== 6'b0) begin n_fail++;
         $display("FAIL reset_done_err_grant: got %b want 000000", {Done, Err, Grant}); end
      n_chk++; if ({IIC_Write, IIC_Read, Reg_2Addr} !== 3'b0) begin n_fail++;
         $display("FAIL reset_strobes: got %b want 000", {IIC_Write, IIC_Read, Reg_2Addr}); end
      n_chk++; if ({Addr, Reg_Addr, Data} !== 32'h0) begin n_fail++;
         $display("FAIL reset_driver_fields: got %h want 0", {Addr, Reg_Addr, Data}); end
      n_chk++; if (Rd_Data !== 8'h00) begin n_fail++;
         $display("FAIL reset_rd_data: got %h want 00", Rd_Data); end
   endtask

   task automatic test_single_write();
      obs_t o;
      Req_Rd[0] = 1'b0; Req_Addr0 = 8'h6C; Req_Reg_Addr0 = 16'h0100; Req_Data0 = 8'h01;
      Req_Reg2Addr[0] = 1'b1;
      Req = 2'b01;
      drive_txn(3, 50, 8'hEE, 200, o);
      n_chk++; if (o.s_lat !== 1) begin n_fail++;
         $display("FAIL wr_strobe_latency: got %0d want 1", o.s_lat); end
      n_chk++; if ({o.s_wr, o.s_rd} !== 2'b10) begin n_fail++;
         $display("FAIL wr_strobe_kind: got %b want 10", {o.s_wr, o.s_rd}); end
      n_chk++; if (o.s_fields !== {8'h6C, 16'h0100, 8'h01, 1'b1}) begin n_fail++;
         $display("FAIL wr_fields: got %h want %h", o.s_fields, {8'h6C, 16'h0100, 8'h01, 1'b1}); end
      n_chk++; if (o.s_gnt !== 2'b01) begin n_fail++;
         $display("FAIL wr_grant: got %b want 01", o.s_gnt); end
      n_chk++; if (o.d_t !== exp_done_t(3, 50)) begin n_fail++;
         $display("FAIL wr_done_latency: got %0d want %0d", o.d_t, exp_done_t(3, 50)); end
      n_chk++; if ({o.d_done, o.d_err} !== 4'b0100) begin n_fail++;
         $display("FAIL wr_done_err: got %b want 0100", {o.d_done, o.d_err}); end
      n_chk++; if (o.d_rdata !== model_rd) begin n_fail++;
         $display("FAIL wr_rd_data: got %h want %h", o.d_rdata, model_rd); end
      Req = 2'b00; last_srv = 0;
      repeat (3) @(negedge clk);
      n_chk++; if ({Addr, Reg_Addr, Data, Grant} !== {8'h6C, 16'h0100, 8'h01, 2'b00}) begin n_fail++;
         $display("FAIL idle_hold: got %h want %h", {Addr, Reg_Addr, Data, Grant},
                  {8'h6C, 16'h0100, 8'h01, 2'b00}); end
   endtask

   task automatic test_contention();
      obs_t o;
      int   d, L, w;
      logic [1:0] want;
      apply_reset();
      set_fields(0); set_fields(1);
      Req = 2'b11;
      for (int k = 0; k < 3; k++) begin
         w = rr_pick(Req, last_srv);
         want = (k == 1) ? 2'b10 : 2'b01;
         d = $urandom_range(START_WAIT, 1); L = $urandom_range(40, 1);
         drive_txn(d, L, 8'($urandom), 200, o);
         if (Req_Rd[w]) model_rd = IIC_Read_Data;
         n_chk++; if (o.s_lat !== ((k == 0) ? 1 : 2)) begin n_fail++;
            $display("FAIL cont_latency[%0d]: got %0d want %0d", k, o.s_lat, (k == 0) ? 1 : 2); end
         n_chk++; if (o.s_gnt !== want) begin n_fail++;
            $display("FAIL cont_grant[%0d]: got %b want %b", k, o.s_gnt, want); end
         n_chk++; if (o.s_fields !== exp_fields(w)) begin n_fail++;
            $display("FAIL cont_fields[%0d]: got %h want %h", k, o.s_fields, exp_fields(w)); end
         n_chk++; if ({o.s_wr, o.s_rd, o.extra} !== {~Req_Rd[w], Req_Rd[w], 32'd0}) begin n_fail++;
            $display("FAIL cont_strobes[%0d]: got wr=%b rd=%b extra=%0d", k, o.s_wr, o.s_rd, o.extra); end
         n_chk++; if ({o.d_done, o.d_err} !== {want, 2'b00}) begin n_fail++;
            $display("FAIL cont_done[%0d]: got %b want %b00", k, {o.d_done, o.d_err}, want); end
         n_chk++; if (o.d_t !== exp_done_t(d, L)) begin n_fail++;
            $display("FAIL cont_done_latency[%0d]: got %0d want %0d", k, o.d_t, exp_done_t(d, L)); end
         last_srv = w;
      end
      Req = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_read();
      obs_t o;
      Req_Rd[1] = 1'b1; Req_Addr1 = 8'h6C; Req_Reg_Addr1 = 16'h3500; Req_Reg2Addr[1] = 1'b1;
      Req = 2'b10;
      drive_txn(2, 10, 8'h5A, 200, o);
      n_chk++; if ({o.s_wr, o.s_rd} !== 2'b01) begin n_fail++;
         $display("FAIL rd_strobe_kind: got %b want 01", {o.s_wr, o.s_rd}); end
      n_chk++; if (o.s_fields[24:9] !== 16'h3500) begin n_fail++;
         $display("FAIL rd_reg_addr: got %h want 3500", o.s_fields[24:9]); end
      n_chk++; if ({o.d_done, o.d_err, o.d_rdata} !== {2'b10, 2'b00, 8'h5A}) begin n_fail++;
         $display("FAIL rd_done: got %h want %h", {o.d_done, o.d_err, o.d_rdata}, {2'b10, 2'b00, 8'h5A}); end
      Req = 2'b00; last_srv = 1; model_rd = 8'h5A;
      @(negedge clk);
      set_fields(0); Req_Rd[0] = 1'b0;
      Req = 2'b01;
      drive_txn(2, 5, 8'hC3, 200, o);
      n_chk++; if ({o.d_done, o.d_rdata} !== {2'b01, model_rd}) begin n_fail++;
         $display("FAIL rd_data_hold: got %h want %h", {o.d_done, o.d_rdata}, {2'b01, model_rd}); end
      Req = 2'b00; last_srv = 0;
      @(negedge clk);
   endtask

   task automatic test_start_timeout();
      obs_t o;
      set_fields(0); Req_Rd[0] = 1'b1;
      Req = 2'b01;
      drive_txn(0, 0, 8'h77, 100, o);
      n_chk++; if (o.d_t !== exp_done_t(0, 0)) begin n_fail++;
         $display("FAIL st_to_latency: got %0d want %0d", o.d_t, exp_done_t(0, 0)); end
      n_chk++; if ({o.d_done, o.d_err} !== {2'b01, {1'b0, exp_err(0, 0)}}) begin n_fail++;
         $display("FAIL st_to_done_err: got %b want 0101", {o.d_done, o.d_err}); end
      n_chk++; if (o.d_rdata !== model_rd) begin n_fail++;
         $display("FAIL st_to_rd_data: got %h want %h", o.d_rdata, model_rd); end
      Req = 2'b00; last_srv = 0;
      @(negedge clk);
      set_fields(1); Req_Rd[1] = 1'b0;
      Req = 2'b10;
      drive_txn(4, 6, 8'h00, 200, o);
      n_chk++; if ({o.s_lat, o.d_t, o.d_done, o.d_err} !== {32'd1, exp_done_t(4, 6), 2'b10, 2'b00}) begin
         n_fail++;
         $display("FAIL st_to_recover: got lat=%0d t=%0d done=%b err=%b", o.s_lat, o.d_t, o.d_done, o.d_err); end
      Req = 2'b00; last_srv = 1;
      @(negedge clk);
   endtask

   task automatic test_busy_timeout();
      obs_t o;
      int   n_bad;
      set_fields(1); Req_Rd[1] = 1'b0;
      Req = 2'b10;
      drive_txn(2, -1, 8'h00, 300, o);
      n_chk++; if (o.d_t !== exp_done_t(2, -1)) begin n_fail++;
         $display("FAIL busy_to_latency: got %0d want %0d", o.d_t, exp_done_t(2, -1)); end
      n_chk++; if ({o.d_done, o.d_err} !== 4'b1010) begin n_fail++;
         $display("FAIL busy_to_done_err: got %b want 1010", {o.d_done, o.d_err}); end
      Req = 2'b00; last_srv = 1;
      @(negedge clk);
      set_fields(0); Req_Rd[0] = 1'b0;
      Req = 2'b01;
      n_bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (IIC_Write || IIC_Read || Grant != 2'b00) n_bad++;
      end
      n_chk++; if (n_bad !== 0) begin n_fail++;
         $display("FAIL busy_idle_hold: got %0d active cycles want 0", n_bad); end
      IIC_Busy = 1'b0;
      drive_txn(3, 5, 8'h00, 200, o);
      n_chk++; if ({o.s_lat, o.s_gnt, o.d_done, o.d_err} !== {32'd1, 2'b01, 2'b01, 2'b00}) begin n_fail++;
         $display("FAIL busy_release: got lat=%0d gnt=%b done=%b err=%b", o.s_lat, o.s_gnt, o.d_done, o.d_err); end
      Req = 2'b00; last_srv = 0;
      @(negedge clk);
   endtask

   task automatic test_reset_midflight();
      obs_t o;
      int   k, n_bad;
      // reset during the strobe cycle
      set_fields(1); Req_Rd[1] = 1'b0;
      Req = 2'b10;
      k = 0;
      while (k < 8 && !(IIC_Write || IIC_Read)) begin @(negedge clk); k++; end
      #1 Rst_N = 1'b0;
      #1;
      n_chk++; if ({k < 8, IIC_Write, IIC_Read} !== 3'b100) begin n_fail++;
         $display("FAIL rst_launch_strobe: got seen=%0d wr=%b rd=%b want 1 0 0", k < 8, IIC_Write, IIC_Read); end
      Req = 2'b00;
      @(negedge clk);
      Rst_N = 1'b1; last_srv = 1; model_rd = 8'h00;
      @(negedge clk);
      // a read from requester 0 so Rd_Data is non-zero before the abort
      set_fields(0); Req_Rd[0] = 1'b1;
      Req = 2'b01;
      drive_txn(2, 4, 8'hA5, 200, o);
      Req = 2'b00; last_srv = 0; model_rd = 8'hA5;
      n_chk++; if (o.d_rdata !== 8'hA5) begin n_fail++;
         $display("FAIL pre_rst_read: got %h want a5", o.d_rdata); end
      @(negedge clk);
      Req = 2'b01;
      k = 0;
      while (k < 8 && !(IIC_Write || IIC_Read)) begin @(negedge clk); k++; end
      IIC_Busy = 1'b1;
      repeat (10) @(negedge clk);
      #2 Rst_N = 1'b0;
      #1;
      n_chk++; if ({Grant, Done, Err, IIC_Write, IIC_Read} !== 8'h00) begin n_fail++;
         $display("FAIL rst_mid_outputs: got %b want 00000000", {Grant, Done, Err, IIC_Write, IIC_Read}); end
      n_chk++; if ({Addr, Rd_Data} !== 16'h0000) begin n_fail++;
         $display("FAIL rst_mid_regs: got %h want 0000", {Addr, Rd_Data}); end
      Req = 2'b00; IIC_Busy = 1'b0;
      @(negedge clk);
      Rst_N = 1'b1; last_srv = 1; model_rd = 8'h00;
      n_bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (Done != 2'b00 || Err != 2'b00) n_bad++;
      end
      n_chk++; if (n_bad !== 0) begin n_fail++;
         $display("FAIL rst_no_done: got %0d pulses want 0", n_bad); end
      set_fields(0); set_fields(1);
      Req = 2'b11;
      drive_txn(3, 3, 8'h3C, 200, o);
      n_chk++; if ({o.s_gnt, o.d_done} !== 4'b0101) begin n_fail++;
         $display("FAIL rst_pointer: got gnt=%b done=%b want 01 01", o.s_gnt, o.d_done); end
      if (Req_Rd[0]) model_rd = 8'h3C;
      Req = 2'b00; last_srv = 0;
      @(negedge clk);
   endtask

   task automatic test_random(input int nr);
      obs_t o;
      int   w, d, L, it, rsel;
      logic [7:0]  rdat;
      logic        rd_exp;
      logic [32:0] f_exp;
      it = 0;
      while ((it < nr) || ((Req != 2'b00) && (it < nr + 4))) begin
         if (it < nr) begin
            for (int r = 0; r < 2; r++)
               if (!Req[r] && $urandom_range(1, 0) == 1) begin set_fields(r); Req[r] = 1'b1; end
            if (Req == 2'b00) begin
               rsel = $urandom_range(1, 0); set_fields(rsel); Req[rsel] = 1'b1;
            end
         end
         w = rr_pick(Req, last_srv);
         rd_exp = Req_Rd[w];
         f_exp = exp_fields(w);
         d = ($urandom_range(3, 0) == 0) ? START_WAIT : int'($urandom_range(START_WAIT, 1));
         L = ($urandom_range(3, 0) == 0) ? BUSY_TO : int'($urandom_range(BUSY_TO, 1));
         rdat = 8'($urandom);
         drive_txn(d, L, rdat, START_WAIT + BUSY_TO + 10, o);
         if (rd_exp) model_rd = rdat;
         n_chk++; if (o.s_lat !== ((it == 0) ? 1 : 2)) begin n_fail++;
            $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, o.s_lat, (it == 0) ? 1 : 2); end
         n_chk++; if (o.s_gnt !== 2'(1 << w)) begin n_fail++;
            $display("FAIL rnd_grant[%0d]: got %b want %b", it, o.s_gnt, 2'(1 << w)); end
         n_chk++; if ({o.s_wr, o.s_rd, o.extra} !== {~rd_exp, rd_exp, 32'd0}) begin n_fail++;
            $display("FAIL rnd_strobes[%0d]: got wr=%b rd=%b extra=%0d", it, o.s_wr, o.s_rd, o.extra); end
         n_chk++; if (o.s_fields !== f_exp) begin n_fail++;
            $display("FAIL rnd_fields[%0d]: got %h want %h", it, o.s_fields, f_exp); end
         n_chk++; if (o.d_t !== exp_done_t(d, L)) begin n_fail++;
            $display("FAIL rnd_done_latency[%0d]: got %0d want %0d", it, o.d_t, exp_done_t(d, L)); end
         n_chk++; if ({o.d_done, o.d_err} !== {2'(1 << w), 2'b00}) begin n_fail++;
            $display("FAIL rnd_done_err[%0d]: got %b want %b00", it, {o.d_done, o.d_err}, 2'(1 << w)); end
         n_chk++; if (o.d_rdata !== model_rd) begin n_fail++;
            $display("FAIL rnd_rd_data[%0d]: got %h want %h", it, o.d_rdata, model_rd); end
         Req[w] = 1'b0;
         last_srv = w;
         it++;
      end
      Req = 2'b00;
      @(negedge clk);
   endtask

   initial begin
      Rst_N = 1'b0; Req = 2'b00; Req_Rd = 2'b00; Req_Reg2Addr = 2'b00;
      Req_Addr0 = 8'h00; Req_Addr1 = 8'h00; Req_Data0 = 8'h00; Req_Data1 = 8'h00;
      Req_Reg_Addr0 = 16'h0; Req_Reg_Addr1 = 16'h0;
      IIC_Busy = 1'b0; IIC_Read_Data = 8'h00;
      last_srv = 1; model_rd = 8'h00;
      test_reset();
      test_single_write();
      test_contention();
      test_read();
      test_start_timeout();
      test_busy_timeout();
      test_reset_midflight();
      test_random(40);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
